// File: rtl/param_serial_tx.sv
// Parameter-word serial transmitter: load_params pulse, then MSB-first shift per ack.
// Optional watchdog enabled by defining PARAM_TX_TIMEOUT_EN.
module param_serial_tx #(
  parameter int DATA_WIDTH     = 312,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] param_word,
  input  logic                  data_written,
  input  logic                  end_writing,
  output logic                  load_params,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SEND,
    S_WAIT_END,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         bit_cnt;
  logic                  error_q;
  logic                  ack_last;
  logic                  wd_hit;

  assign ack_last = data_written
                  && (bit_cnt == CW'(DATA_WIDTH - 1));

`ifdef PARAM_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd;

  assign wd_hit = (wd == WW'(TIMEOUT_CYCLES - 1));

  // Restarts on every state change and on every ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd <= '0;
    end else if (state_d != state_q || data_written) begin
      wd <= '0;
    end else if (state_q == S_SEND || state_q == S_WAIT_END) begin
      wd <= wd + WW'(1);
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ARM;
      end
      S_ARM: begin
        state_d = data_written ? S_ERROR : S_SEND;
      end
      S_SEND: begin
        if (ack_last) begin
          state_d = end_writing ? S_DONE : S_WAIT_END;
        end else if (end_writing) begin
          state_d = S_ERROR;
        end else if (!data_written && wd_hit) begin
          state_d = S_ERROR;
        end
      end
      S_WAIT_END: begin
        if (data_written) begin
          state_d = S_ERROR;
        end else if (end_writing) begin
          state_d = S_DONE;
        end else if (wd_hit) begin
          state_d = S_ERROR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (state_q == S_IDLE && start) begin
      shreg   <= param_word;
      bit_cnt <= '0;
    end else if (state_q == S_SEND && data_written) begin
      shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      error_q <= 1'b0;
    end else if (state_d == S_ERROR) begin
      error_q <= 1'b1;
    end
  end

  always_comb begin
    load_params = 1'b0;
    serial_out  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    error       = error_q;
    unique case (state_q)
      S_ARM: begin
        load_params = 1'b1;
        busy        = 1'b1;
      end
      S_SEND: begin
        serial_out = shreg[DATA_WIDTH-1];
        busy       = 1'b1;
      end
      S_WAIT_END: busy = 1'b1;
      S_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_param_serial_tx.sv
// Scoreboard bench for param_serial_tx (DATA_WIDTH=8, TIMEOUT_CYCLES=16).
// Reference: bit i of a transfer is word[7-i]; events are done or error.
module tb_param_serial_tx;

  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] param_word = '0;
  logic          data_written = 1'b0;
  logic          end_writing = 1'b0;
  logic          load_params;
  logic          serial_out;
  logic          busy;
  logic          done;
  logic          error;

  int   n_chk = 0;
  int   n_pass = 0;
  bit   exp_bits[$];
  int   exp_evt[$];
  logic err_prev = 1'b0;

  param_serial_tx #(
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .param_word(param_word),
    .data_written(data_written),
    .end_writing(end_writing),
    .load_params(load_params),
    .serial_out(serial_out),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expected bit on each ack and the expected event
  // whenever done pulses or error rises.
  always @(negedge clk) begin
    if (data_written && busy) begin
      if (exp_bits.size() == 0) chk("bit_unexpected", 1, 0);
      else chk("serial_bit", serial_out, exp_bits.pop_front());
    end
    if (done) begin
      if (exp_evt.size() == 0) chk("done_unexpected", 1, 0);
      else chk("event_done", 1, exp_evt.pop_front());
    end
    if (error && !err_prev) begin
      if (exp_evt.size() == 0) chk("error_unexpected", 1, 0);
      else chk("event_error", 2, exp_evt.pop_front());
    end
    err_prev = error;
  end

  task automatic ack(bit b, bit last_end);
    exp_bits.push_back(b);
    data_written = 1'b1;
    end_writing  = last_end;
    tick();
    data_written = 1'b0;
    end_writing  = 1'b0;
  endtask

  task automatic begin_word(logic [DW-1:0] w);
    param_word = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_pulse", load_params, 1);
    chk("busy_arm", busy, 1);
    tick();
    chk("load_once", load_params, 0);
  endtask

  task automatic send_word(logic [DW-1:0] w, int maxgap,
                           int end_delay, bit restart);
    int gap;
    exp_evt.push_back(1);
    begin_word(w);
    for (int i = 0; i < DW; i++) begin
      gap = $urandom_range(0, maxgap);
      if (restart && i == 3) begin
        start = 1'b1;
        param_word = ~w;
        tick();
        start = 1'b0;
        chk("restart_busy", busy, 1);
      end
      for (int g = 0; g < gap; g++) begin
        chk("bit_hold", serial_out, w[DW-1-i]);
        tick();
      end
      ack(w[DW-1-i], i == DW - 1 && end_delay == 0);
    end
    if (end_delay > 0) begin
      repeat (end_delay) tick();
      chk("wait_end_busy", busy, 1);
      end_writing = 1'b1;
      tick();
      end_writing = 1'b0;
    end
    chk("done_pulse", done, 1);
    tick();
    chk("done_clear", done, 0);
    chk("busy_clear", busy, 0);
    chk("error_clean", error, 0);
    chk("serial_idle", serial_out, 0);
  endtask

  initial begin
    logic [DW-1:0] w;
    #2;
    chk("rst_load", load_params, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_serial", serial_out, 0);
    tick();
    rst_n = 1'b1;
    tick();

    send_word(8'hA5, 0, 0, 1'b0);
    send_word(8'h3C, 5, 3, 1'b0);

    // Premature end_writing after the fifth ack.
    w = DW'($urandom);
    exp_evt.push_back(2);
    begin_word(w);
    for (int i = 0; i < 5; i++) ack(w[DW-1-i], 1'b0);
    end_writing = 1'b1;
    tick();
    end_writing = 1'b0;
    chk("err_set", error, 1);
    chk("err_busy", busy, 0);
    tick();
    tick();
    chk("err_sticky", error, 1);
    send_word(DW'($urandom), 2, 1, 1'b0);

    send_word(8'h96, 2, 0, 1'b1);

    // Reset after the fourth ack.
    w = DW'($urandom);
    begin_word(w);
    for (int i = 0; i < 4; i++) ack(w[DW-1-i], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_serial", serial_out, 0);
    chk("abort_error", error, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_word(w, 1, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      send_word(DW'($urandom), $urandom_range(0, 4),
                $urandom_range(0, 4), 1'b0);
    end

    // Silent receiver in SEND.
    w = DW'($urandom);
`ifdef PARAM_TX_TIMEOUT_EN
    exp_evt.push_back(2);
`endif
    begin_word(w);
    repeat (TO + 4) tick();
`ifdef PARAM_TX_TIMEOUT_EN
    chk("timeout_err", error, 1);
    chk("timeout_busy", busy, 0);
`else
    chk("no_timeout_busy", busy, 1);
    chk("no_timeout_err", error, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif
    tick();
    chk("bits_drained", exp_bits.size(), 0);
    chk("events_drained", exp_evt.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
